// File: rtl/md_unit.sv
// Multiply/divide unit: multi-cycle mult/div into private HI/LO with a busy interlock.
// Define MD_MADD_EN to accept the madd/maddu/msub/msubu accumulate codes (9..12).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } md_op_e;

  logic [31:0] ph, pl;
  logic        pwe;
  logic [3:0]  count;

  // Products: sign- or zero-extend to 64 bits; the low 64 bits of the product are exact.
  logic [63:0] mul_s, mul_u;
  assign mul_s = {{32{src0[31]}}, src0} * {{32{src1[31]}}, src1};
  assign mul_u = {32'd0, src0} * {32'd0, src1};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo_s, rem_s;
  logic [31:0] u_safe, quo_u, rem_u;

  assign a_neg  = src0[31];
  assign b_neg  = src1[31];
  assign a_mag  = a_neg ? -src0 : src0;
  assign b_mag  = b_neg ? -src1 : src1;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo_s  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_s  = a_neg ? -r_mag : r_mag;
  assign u_safe = (src1 == 32'd0) ? 32'd1 : src1;
  assign quo_u  = src0 / u_safe;
  assign rem_u  = src0 % u_safe;

  logic [63:0] result;
  logic        result_we;
  logic [3:0]  cycles;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    start     = 1'b0;
    result    = 64'd0;
    result_we = 1'b1;
    cycles    = 4'(MULT_CYCLES);
    case (md_op)
      OP_MULT:  begin start = 1'b1; result = mul_s; end
      OP_MULTU: begin start = 1'b1; result = mul_u; end
      OP_DIV: begin
        start     = 1'b1;
        result    = {rem_s, quo_s};
        result_we = (src1 != 32'd0);
        cycles    = 4'(DIV_CYCLES);
      end
      OP_DIVU: begin
        start     = 1'b1;
        result    = {rem_u, quo_u};
        result_we = (src1 != 32'd0);
        cycles    = 4'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin start = 1'b1; result = {hi_q, lo_q} + mul_s; end
      OP_MADDU: begin start = 1'b1; result = {hi_q, lo_q} + mul_u; end
      OP_MSUB:  begin start = 1'b1; result = {hi_q, lo_q} - mul_s; end
      OP_MSUBU: begin start = 1'b1; result = {hi_q, lo_q} - mul_u; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI)      md_out = hi_q;
    else if (md_op == OP_MFLO) md_out = lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      pwe   <= 1'b0;
      count <= 4'd0;
      busy  <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        ph    <= result[63:32];
        pl    <= result[31:0];
        pwe   <= result_we;
        count <= cycles;
        busy  <= 1'b1;
      end else if (md_op == OP_MTHI) begin
        hi_q <= src0;
      end else if (md_op == OP_MTLO) begin
        lo_q <= src0;
      end
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        busy <= 1'b0;
        // A divide by zero still occupies the unit but leaves HI/LO untouched.
        if (pwe) begin
          hi_q <= ph;
          lo_q <= pl;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO/latency, monitor checks on busy fall.
// Reference model uses plain 64-bit integer arithmetic; honours MD_MADD_EN like the DUT.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                         MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8,
                         MADD = 4'd9, MADDU = 4'd10, MSUB = 4'd11, MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src0 = 32'd0, src1 = 32'd0;
  logic        start, busy;
  logic [31:0] md_out, hi_q, lo_q;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .src0(src0), .src1(src1),
    .start(start), .busy(busy), .md_out(md_out), .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } wb_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_t;

  wb_t wb_q[$];
  rd_t rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks writeback and busy length whenever busy falls, and md_out on mfhi/mflo.
  int  bcnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      bcnt      = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) bcnt++;
      if (prev_busy && !busy) begin
        if (wb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_writeback: got hi=0x%0h lo=0x%0h expected no operation", hi_q, lo_q);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          check({e.name, "_hi"}, 64'(hi_q), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo_q), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(bcnt), 64'(e.cycles));
        end
        bcnt = 0;
      end
      if ((md_op == MFHI || md_op == MFLO) && !busy) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_read: got md_out=0x%0h expected no read", md_out);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check(r.name, 64'(md_out), 64'(r.val));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    md_op = op;
    src0  = a;
    src1  = b;
    #1;
  endtask

  function automatic bit is_start_op(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op >= MULT && op <= DIVU) || (op >= MADD && op <= MSUBU);
`else
    return (op >= MULT && op <= DIVU);
`endif
  endfunction

  // Drives one operation from idle, predicts its effect and queues the expectation.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    acc = {m_hi, m_lo};
    drive(op, a, b);
    check({name, "_start"}, 64'(start), 64'(is_start_op(op)));
    case (op)
      MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_hi = r[31:0];
        m_lo = q[31:0];
      end
      DIVU: if (b != 0) begin
        m_hi = 32'(ua % ub);
        m_lo = 32'(ua / ub);
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      MFHI: rd_q.push_back('{name: name, val: m_hi});
      MFLO: rd_q.push_back('{name: name, val: m_lo});
`ifdef MD_MADD_EN
      MADD:  begin p = acc + longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      MADDU: begin p = acc + ua * ub;           m_hi = p[63:32]; m_lo = p[31:0]; end
      MSUB:  begin p = acc - longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      MSUBU: begin p = acc - ua * ub;           m_hi = p[63:32]; m_lo = p[31:0]; end
`endif
      default: ;
    endcase
    if (is_start_op(op))
      wb_q.push_back('{name: name, hi: m_hi, lo: m_lo,
                       cycles: (op == DIV || op == DIVU) ? DIV_N : MULT_N});
    drive(NONE, 32'd0, 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || wb_q.size() != 0) && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 60) check("idle_timeout_pending", 64'(wb_q.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] ops[$];
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO};
`ifdef MD_MADD_EN
    ops.push_back(MADD);
    ops.push_back(MADDU);
    ops.push_back(MSUB);
    ops.push_back(MSUBU);
`endif

    // Power-on reset.
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi_q), 64'd0);
    check("reset_lo", 64'(lo_q), 64'd0);
    #2 reset = 1'b0;

    // Reset in cycle 2 of a mult discards it and clears HI/LO.
    issue(MTHI, 32'hA5A5_A5A5, 32'd0, "pre_mthi");
    issue(MTLO, 32'h5A5A_5A5A, 32'd0, "pre_mtlo");
    issue(MFHI, 32'd0, 32'd0, "pre_mfhi");
    drive(MULT, 32'h1234_5678, 32'h0000_0777);
    drive(NONE, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("midop_reset_busy", 64'(busy), 64'd0);
    check("midop_reset_hi", 64'(hi_q), 64'd0);
    check("midop_reset_lo", 64'(lo_q), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("after_reset_no_wb_hi", 64'(hi_q), 64'd0);
    check("after_reset_no_wb_lo", 64'(lo_q), 64'd0);
    check("after_reset_busy", 64'(busy), 64'd0);

    // mult / multu of 0xFFFFFFFE * 3.
    issue(MULT, 32'hFFFF_FFFE, 32'd3, "mult_m2x3");
    wait_idle();
    check("mult_m2x3_hi_const", 64'(hi_q), 64'hFFFF_FFFF);
    check("mult_m2x3_lo_const", 64'(lo_q), 64'hFFFF_FFFA);
    issue(MULTU, 32'hFFFF_FFFE, 32'd3, "multu_m2x3");
    wait_idle();
    check("multu_hi_const", 64'(hi_q), 64'h0000_0002);
    check("multu_lo_const", 64'(lo_q), 64'hFFFF_FFFA);

    // div -7/2, then divu by zero leaves HI/LO alone.
    issue(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    wait_idle();
    check("div_m7_2_lo_const", 64'(lo_q), 64'hFFFF_FFFD);
    check("div_m7_2_hi_const", 64'(hi_q), 64'hFFFF_FFFF);
    issue(DIVU, 32'd7, 32'd0, "divu_by_zero");
    wait_idle();

    // Overflowing signed divide; mult and mtlo presented while busy are ignored.
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    drive(MULT, 32'd5, 32'd7);
    check("start_while_busy_reported", 64'(start), 64'd1);
    drive(NONE, 32'd0, 32'd0);
    drive(MTLO, 32'hDEAD_BEEF, 32'd0);
    drive(NONE, 32'd0, 32'd0);
    wait_idle();
    check("div_ovf_lo_const", 64'(lo_q), 64'h8000_0000);
    check("div_ovf_hi_const", 64'(hi_q), 64'h0000_0000);
    repeat (3) @(negedge clk);
    check("ignored_mult_no_busy", 64'(busy), 64'd0);

    // mthi then mfhi on the next cycle.
    issue(MTHI, 32'h1234_5678, 32'd0, "mthi");
    issue(MFHI, 32'd0, 32'd0, "mfhi_after_mthi");
    issue(MFLO, 32'd0, 32'd0, "mflo_after_busy_mtlo");

`ifdef MD_MADD_EN
    issue(MTHI, 32'd0, 32'd0, "madd_prep_hi");
    issue(MTLO, 32'hFFFF_FFFF, 32'd0, "madd_prep_lo");
    issue(MADDU, 32'd1, 32'd1, "maddu_carry");
    wait_idle();
    check("maddu_hi_const", 64'(hi_q), 64'd1);
    check("maddu_lo_const", 64'(lo_q), 64'd0);
`else
    drive(MADDU, 32'd3, 32'd4);
    check("code10_start", 64'(start), 64'd0);
    drive(NONE, 32'd0, 32'd0);
    repeat (8) @(negedge clk);
    check("code10_busy", 64'(busy), 64'd0);
    check("code10_hi", 64'(hi_q), 64'(m_hi));
    check("code10_lo", 64'(lo_q), 64'(m_lo));
`endif

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(ops.size() - 1)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(9));
        default: ;
      endcase
      issue(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      if (is_start_op(op)) wait_idle();
    end
    issue(MFHI, 32'd0, 32'd0, "final_mfhi");
    issue(MFLO, 32'd0, 32'd0, "final_mflo");
    wait_idle();
    check("leftover_reads", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
